// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MULTU in EX.
// Optional HI/LO register file behind `MUL_HILO_EN.
module mul_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MUL_HILO_EN
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
`endif
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic [WIDTH-1:0]     res_hi_q;
  logic [WIDTH-1:0]     res_lo_q;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     acc_add;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic                 last;
  logic                 run;

  assign run = (state_q == RUN);

  // Multiplier lives in the low half of acc and shifts out as product bits shift in
  always_comb begin
    abs_a   = (is_signed && a[WIDTH-1]) ? -a : a;
    abs_b   = (is_signed && b[WIDTH-1]) ? -b : b;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    acc_add = acc_q[0] ? {sum, acc_q[WIDTH-1:0]}
                       : {1'b0, acc_q};
    acc_d   = acc_add[2*WIDTH:1];
    prod    = neg_q ? -acc_d : acc_d;
    last    = (cnt_q == CNT_W'(WIDTH-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q <= abs_a;
            acc_q   <= {{WIDTH{1'b0}}, abs_b};
            neg_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) begin
            res_hi_q <= prod[2*WIDTH-1:WIDTH];
            res_lo_q <= prod[WIDTH-1:0];
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MUL_HILO_EN
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Explicit MTHI/MTLO beats the product load on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!run) begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end else if (last) begin
      hi_q <= hi_we ? hi_wdata : prod[2*WIDTH-1:WIDTH];
      lo_q <= lo_we ? lo_wdata : prod[WIDTH-1:0];
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
`endif

  assign busy      = run;
  assign done      = (state_q == DONE);
  assign stall_req = run | (start & ~run);
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;

endmodule
